// File: rtl/icache_controller.sv
// rtl/icache_controller.sv - read-only instruction cache control FSM with round-robin fill and hit/miss counters
module icache_controller #(
    parameter int ADDR_SIZE = 32,
    parameter int NUM_SETS = 16,
    parameter int NUM_WAYS = 4,
    parameter int BLOCK_SIZE = 32,
    localparam int OFFSET_SIZE = $clog2(BLOCK_SIZE / 4),
    localparam int SET_SIZE = $clog2(NUM_SETS),
    localparam int TAG_SIZE = ADDR_SIZE - SET_SIZE - OFFSET_SIZE,
    localparam int WAY_SIZE = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_SIZE-1:0]  req_addr,
    output logic                  resp_valid,
    output logic [BLOCK_SIZE-1:0] resp_rdata,
    output logic [SET_SIZE-1:0]   cm_set,
    output logic [TAG_SIZE-1:0]   cm_tag,
    output logic                  cm_write_enable,
    output logic [WAY_SIZE-1:0]   cm_write_way,
    output logic [BLOCK_SIZE-1:0] cm_write_data,
    input  logic [BLOCK_SIZE-1:0] cm_read_data,
    input  logic                  cm_hit,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_SIZE-1:0]  mem_req_addr,
    input  logic                  mem_resp_valid,
    input  logic [BLOCK_SIZE-1:0] mem_resp_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MEM_REQ,
        MEM_WAIT,
        FILL
    } state_t;

    state_t                state;
    logic [ADDR_SIZE-1:0]  addr_q;
    logic [BLOCK_SIZE-1:0] fill_data;
    logic [WAY_SIZE-1:0]   rr [NUM_SETS];
    logic [31:0]           hit_count_q;
    logic [31:0]           miss_count_q;
    logic                  req_ready_q;
    logic                  mem_req_valid_q;
    logic                  fill_q;
    logic                  lookup_hit;
    logic [SET_SIZE-1:0]   set_idx;
    logic                  unused_offset;

    assign set_idx       = addr_q[SET_SIZE+OFFSET_SIZE-1:OFFSET_SIZE];
    assign cm_set        = set_idx;
    assign cm_tag        = addr_q[ADDR_SIZE-1:SET_SIZE+OFFSET_SIZE];
    assign mem_req_addr  = {addr_q[ADDR_SIZE-1:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};
    assign unused_offset = ^addr_q[OFFSET_SIZE-1:0];

    // A hit is answered straight from the array in the LOOKUP cycle so the
    // controller is back in IDLE one cycle later (2-cycle request spacing).
    assign lookup_hit      = (state == LOOKUP) && cm_hit;
    assign resp_valid      = lookup_hit || fill_q;
    assign resp_rdata      = lookup_hit ? cm_read_data : (fill_q ? fill_data : '0);

    assign req_ready       = req_ready_q;
    assign mem_req_valid   = mem_req_valid_q;
    assign cm_write_enable = fill_q;
    assign cm_write_way    = fill_q ? rr[set_idx] : '0;
    assign cm_write_data   = fill_q ? fill_data : '0;
    assign hit_count       = hit_count_q;
    assign miss_count      = miss_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            addr_q          <= '0;
            fill_data       <= '0;
            hit_count_q     <= '0;
            miss_count_q    <= '0;
            req_ready_q     <= 1'b1;
            mem_req_valid_q <= 1'b0;
            fill_q          <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                rr[s] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q      <= req_addr;
                        req_ready_q <= 1'b0;
                        state       <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (cm_hit) begin
                        if (hit_count_q != 32'hFFFF_FFFF) begin
                            hit_count_q <= hit_count_q + 32'd1;
                        end
                        req_ready_q <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        if (miss_count_q != 32'hFFFF_FFFF) begin
                            miss_count_q <= miss_count_q + 32'd1;
                        end
                        mem_req_valid_q <= 1'b1;
                        state           <= MEM_REQ;
                    end
                end
                MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        fill_data <= mem_resp_rdata;
                        fill_q    <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    // Power-of-two way count makes the natural wrap the modulo.
                    rr[set_idx] <= rr[set_idx] + 1'b1;
                    fill_q      <= 1'b0;
                    req_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    req_ready_q     <= 1'b1;
                    mem_req_valid_q <= 1'b0;
                    fill_q          <= 1'b0;
                    state           <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_controller.sv
// tb/tb_icache_controller.sv - scoreboard bench for icache_controller
module tb_icache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [3:0]  cm_set;
    logic [24:0] cm_tag;
    logic        cm_write_enable;
    logic [1:0]  cm_write_way;
    logic [31:0] cm_write_data;
    logic [31:0] cm_read_data;
    logic        cm_hit;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] exp_q[$];
    logic [31:0] fill_data_q[$];
    logic [1:0]  way_q[$];
    logic [3:0]  set_q[$];

    int          hs_count = 0;
    int          mem_lat = 3;
    logic [31:0] last_mem_addr = '0;

    logic        model_clear = 1'b1;
    logic [24:0] tag_m [16][4];
    logic [31:0] data_m [16][4];
    logic        valid_m [16][4];

    icache_controller dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .cm_set         (cm_set),
        .cm_tag         (cm_tag),
        .cm_write_enable(cm_write_enable),
        .cm_write_way   (cm_write_way),
        .cm_write_data  (cm_write_data),
        .cm_read_data   (cm_read_data),
        .cm_hit         (cm_hit),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Cache memory array model: combinational lookup, written by fills.
    always_comb begin
        cm_hit = 1'b0;
        cm_read_data = '0;
        for (int w = 0; w < 4; w++) begin
            if (valid_m[cm_set][w] && tag_m[cm_set][w] == cm_tag) begin
                cm_hit = 1'b1;
                cm_read_data = data_m[cm_set][w];
            end
        end
    end

    always @(posedge clk) begin
        if (model_clear) begin
            for (int s = 0; s < 16; s++) begin
                for (int w = 0; w < 4; w++) begin
                    valid_m[s][w] <= 1'b0;
                    tag_m[s][w] <= '0;
                    data_m[s][w] <= '0;
                end
            end
        end else if (cm_write_enable) begin
            valid_m[cm_set][cm_write_way] <= 1'b1;
            tag_m[cm_set][cm_write_way] <= cm_tag;
            data_m[cm_set][cm_write_way] <= cm_write_data;
        end
    end

    // Memory bus responder: one response per handshake after mem_lat cycles.
    initial begin
        logic [31:0] a;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        forever begin
            @(posedge clk);
            if (mem_req_valid && mem_req_ready) begin
                hs_count++;
                a = mem_req_addr;
                last_mem_addr = a;
                repeat (mem_lat - 1) @(posedge clk);
                @(negedge clk);
                mem_resp_valid = 1'b1;
                mem_resp_rdata = mem_data(a);
                @(negedge clk);
                mem_resp_valid = 1'b0;
                mem_resp_rdata = '0;
            end
        end
    end

    // Scoreboard monitor for core responses and array fills.
    always @(negedge clk) begin
        if (resp_valid) begin
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL resp_unexpected: got resp_valid data %h, expected none", resp_rdata);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (resp_rdata !== e) begin
                    mismatched++;
                    $display("FAIL resp_rdata: got %h, expected %h", resp_rdata, e);
                end
            end
        end
        if (cm_write_enable) begin
            compared++;
            if (way_q.size() == 0) begin
                mismatched++;
                $display("FAIL fill_unexpected: got write way %0d set %0d, expected none", cm_write_way, cm_set);
            end else begin
                logic [1:0]  ew;
                logic [3:0]  es;
                logic [31:0] ed;
                ew = way_q.pop_front();
                es = set_q.pop_front();
                ed = fill_data_q.pop_front();
                if (cm_write_way !== ew || cm_set !== es || cm_write_data !== ed) begin
                    mismatched++;
                    $display("FAIL fill: got way %0d set %0d data %h, expected way %0d set %0d data %h",
                             cm_write_way, cm_set, cm_write_data, ew, es, ed);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input bit hit, input logic [1:0] way);
        int n;
        int hs0;
        logic [31:0] ed;
        ed = mem_data({addr[31:3], 3'b000});
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL req_ready_wait: got %b, expected 1", req_ready);
        end
        hs0 = hs_count;
        exp_q.push_back(ed);
        if (!hit) begin
            way_q.push_back(way);
            set_q.push_back(addr[6:3]);
            fill_data_q.push_back(ed);
        end
        req_valid = 1'b1;
        req_addr = addr;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (hit) begin
            compared++;
            if (resp_valid !== 1'b1) begin
                mismatched++;
                $display("FAIL hit_latency: got resp_valid %b, expected 1", resp_valid);
            end
        end
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL resp_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
            way_q.delete();
            set_q.delete();
            fill_data_q.delete();
        end
        if (hit) begin
            compared++;
            if (hs_count != hs0) begin
                mismatched++;
                $display("FAIL hit_no_mem: got %0d handshakes, expected 0", hs_count - hs0);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF;
        mem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        model_clear = 1'b0;
        compared++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0 || cm_write_enable !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got rdy %b rv %b mv %b we %b, expected 1 0 0 0",
                     req_ready, resp_valid, mem_req_valid, cm_write_enable);
        end
        compared++;
        if (hit_count !== 32'd0 || miss_count !== 32'd0 || cm_set !== 4'd0 || cm_tag !== 25'd0 || mem_req_addr !== 32'd0) begin
            mismatched++;
            $display("FAIL reset_data: got hit %h miss %h set %h tag %h maddr %h, expected all 0",
                     hit_count, miss_count, cm_set, cm_tag, mem_req_addr);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_cold_miss;
        mem_lat = 3;
        do_req(32'h0000_0040, 1'b0, 2'd0);
        compared++;
        if (last_mem_addr !== 32'h0000_0040) begin
            mismatched++;
            $display("FAIL cold_mem_addr: got %h, expected 00000040", last_mem_addr);
        end
        compared++;
        if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
            mismatched++;
            $display("FAIL cold_counts: got miss %0d hit %0d, expected 1 0", miss_count, hit_count);
        end
    endtask

    task automatic test_hit_after_fill;
        do_req(32'h0000_0040, 1'b1, 2'd0);
        compared++;
        if (hit_count !== 32'd1 || miss_count !== 32'd1) begin
            mismatched++;
            $display("FAIL hit_counts: got hit %0d miss %0d, expected 1 1", hit_count, miss_count);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        exp_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(32'hDEAD_BEEF);
        req_valid = 1'b1;
        req_addr = 32'h0000_0040;
        @(negedge clk);
        compared++;
        if (resp_valid !== 1'b1 || req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_first: got rv %b rdy %b, expected 1 0", resp_valid, req_ready);
        end
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_ready: got rdy %b rv %b, expected 1 0", req_ready, resp_valid);
        end
        @(negedge clk);
        req_valid = 1'b0;
        compared++;
        if (resp_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL b2b_second: got rv %b, expected 1", resp_valid);
        end
        @(negedge clk);
        compared++;
        if (hit_count !== 32'd3 || exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_count: got hit %0d pending %0d, expected 3 0", hit_count, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_round_robin;
        logic [31:0] addrs [5];
        addrs = '{32'h0000_0098, 32'h0000_0118, 32'h0000_0198, 32'h0000_0218, 32'h0000_0298};
        for (int i = 0; i < 5; i++) begin
            do_req(addrs[i], 1'b0, 2'(i % 4));
        end
        do_req(32'h0000_0098, 1'b0, 2'd1);
        compared++;
        if (miss_count !== 32'd7) begin
            mismatched++;
            $display("FAIL rr_misses: got %0d, expected 7", miss_count);
        end
    endtask

    task automatic test_backpressure;
        int n;
        int hs0;
        logic [31:0] ed;
        ed = mem_data(32'h0000_1238);
        mem_req_ready = 1'b0;
        hs0 = hs_count;
        exp_q.push_back(ed);
        way_q.push_back(2'd0);
        set_q.push_back(4'd7);
        fill_data_q.push_back(ed);
        req_valid = 1'b1;
        req_addr = 32'h0000_123C;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mem_req_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_1238) begin
                mismatched++;
                $display("FAIL bp_hold%0d: got valid %b addr %h, expected 1 00001238", i, mem_req_valid, mem_req_addr);
            end
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (exp_q.size() != 0 || hs_count - hs0 != 1) begin
            mismatched++;
            $display("FAIL bp_handshake: got %0d handshakes %0d pending, expected 1 0", hs_count - hs0, exp_q.size());
            exp_q.delete();
            way_q.delete();
            set_q.delete();
            fill_data_q.delete();
        end
    endtask

    task automatic test_reset_mid_miss;
        int n;
        int hs0;
        mem_lat = 6;
        hs0 = hs_count;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr = 32'h0000_3000;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (hs_count == hs0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        compared++;
        if (mem_req_valid !== 1'b0 || req_ready !== 1'b1 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            mismatched++;
            $display("FAIL abort_reset: got mv %b rdy %b hit %0d miss %0d, expected 0 1 0 0",
                     mem_req_valid, req_ready, hit_count, miss_count);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || hit_count !== 32'd0 || miss_count !== 32'd0) begin
            mismatched++;
            $display("FAIL abort_idle: got rdy %b rv %b hit %0d miss %0d, expected 1 0 0 0",
                     req_ready, resp_valid, hit_count, miss_count);
        end
        mem_lat = 3;
    endtask

    task automatic test_saturation;
        @(negedge clk);
        force dut.hit_count_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.hit_count_q;
        do_req(32'h0000_0040, 1'b1, 2'd0);
        compared++;
        if (hit_count !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("FAIL sat_first: got %h, expected ffffffff", hit_count);
        end
        do_req(32'h0000_0040, 1'b1, 2'd0);
        do_req(32'h0000_0040, 1'b1, 2'd0);
        compared++;
        if (hit_count !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("FAIL sat_hold: got %h, expected ffffffff", hit_count);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cold_miss();
        test_hit_after_fill();
        test_back_to_back();
        test_round_robin();
        test_backpressure();
        test_reset_mid_miss();
        test_saturation();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
